// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types and constants for the register-file write scheduler.
package regfile_write_scheduler_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } rf_wr_entry_t;

endpackage

// File: rtl/rfws_fifo.sv
// DEPTH-entry synchronous FIFO of pending multi-cycle register writes.
// Head entry is presented combinationally; storage itself is not reset.
module rfws_fifo
  import regfile_write_scheduler_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  rf_wr_entry_t wrEntry,
  output rf_wr_entry_t rdEntry,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  rf_wr_entry_t      mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= wrEntry;
  end

  assign rdEntry = mem[rdPtr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register-file write port between WB and the multi-cycle unit,
// tracks reserved destinations and stalls ID. Optional macro: RFWS_STALL_CNT_EN.
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int DEPTH = 2
`ifdef RFWS_STALL_CNT_EN
  , parameter int STALL_CNT_W = 32
`endif
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WB_RegWrite,
  input  logic [REG_ADDR_W-1:0] WB_WriteAddress,
  input  logic [DATA_W-1:0]     WB_WriteData,
  input  logic                  MC_Valid,
  output logic                  MC_Ready,
  input  logic [REG_ADDR_W-1:0] MC_WriteAddress,
  input  logic [DATA_W-1:0]     MC_WriteData,
  input  logic                  MC_Issue,
  input  logic [REG_ADDR_W-1:0] MC_IssueAddress,
  input  logic [REG_ADDR_W-1:0] ID_ReadAddr1,
  input  logic [REG_ADDR_W-1:0] ID_ReadAddr2,
  input  logic [REG_ADDR_W-1:0] ID_DestAddr,
  input  logic                  ID_DestValid,
  output logic                  RF_RegWrite,
  output logic [REG_ADDR_W-1:0] RF_WriteAddress,
  output logic [DATA_W-1:0]     RF_WriteData,
  output logic                  ID_Stall,
  output logic [NUM_REGS-1:0]   Pending
`ifdef RFWS_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] StallCount
`endif
);

  rf_wr_entry_t          headEntry;
  rf_wr_entry_t          mcEntry;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  fifoPush;
  logic                  fifoPop;
  logic                  bypass;
  logic                  portWrite;
  logic [REG_ADDR_W-1:0] portAddr;
  logic [DATA_W-1:0]     portData;
  logic                  commitValid;
  logic [REG_ADDR_W-1:0] commitAddr;
  logic [NUM_REGS-1:0]   pendingQ;
  logic [NUM_REGS-1:0]   pendingNext;

  assign mcEntry  = '{addr: MC_WriteAddress, data: MC_WriteData};
  assign MC_Ready = !fifoFull;

  rfws_fifo #(.DEPTH(DEPTH)) uFifo (
    .clock   (Clock),
    .reset   (Reset),
    .push    (fifoPush),
    .pop     (fifoPop),
    .wrEntry (mcEntry),
    .rdEntry (headEntry),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  // WB is never stalled, so it always wins; queued results beat a fresh bypass.
  always_comb begin
    portWrite = 1'b0;
    portAddr  = WB_WriteAddress;
    portData  = WB_WriteData;
    fifoPop   = 1'b0;
    bypass    = 1'b0;
    if (WB_RegWrite) begin
      portWrite = 1'b1;
    end else if (!fifoEmpty) begin
      portWrite = 1'b1;
      portAddr  = headEntry.addr;
      portData  = headEntry.data;
      fifoPop   = 1'b1;
    end else if (MC_Valid) begin
      portWrite = 1'b1;
      portAddr  = MC_WriteAddress;
      portData  = MC_WriteData;
      bypass    = 1'b1;
    end
  end

  assign fifoPush    = MC_Valid && MC_Ready && !bypass;
  assign commitValid = fifoPop || bypass;
  assign commitAddr  = fifoPop ? headEntry.addr : MC_WriteAddress;

  assign RF_RegWrite     = portWrite && (portAddr != REG_ZERO) && !Reset;
  assign RF_WriteAddress = portAddr;
  assign RF_WriteData    = portData;

  // A fresh reservation outlives a commit of the previous result to the same register.
  always_comb begin
    pendingNext = pendingQ;
    if (commitValid) pendingNext[commitAddr] = 1'b0;
    if (MC_Issue)    pendingNext[MC_IssueAddress] = 1'b1;
    pendingNext[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) pendingQ <= '0;
    else       pendingQ <= pendingNext;
  end

  assign Pending  = pendingQ;
  assign ID_Stall = pendingQ[ID_ReadAddr1] | pendingQ[ID_ReadAddr2]
                  | (ID_DestValid & pendingQ[ID_DestAddr]);

`ifdef RFWS_STALL_CNT_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                          StallCount <= '0;
    else if (ID_Stall && ~&StallCount)  StallCount <= StallCount + STALL_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed and randomized checks of regfile_write_scheduler against a queue-based model.
module tb_regfile_write_scheduler;
  import regfile_write_scheduler_pkg::*;

  localparam int DEPTH = 2;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteAddress;
  logic [31:0] WB_WriteData;
  logic        MC_Valid;
  logic        MC_Ready;
  logic [4:0]  MC_WriteAddress;
  logic [31:0] MC_WriteData;
  logic        MC_Issue;
  logic [4:0]  MC_IssueAddress;
  logic [4:0]  ID_ReadAddr1;
  logic [4:0]  ID_ReadAddr2;
  logic [4:0]  ID_DestAddr;
  logic        ID_DestValid;
  logic        RF_RegWrite;
  logic [4:0]  RF_WriteAddress;
  logic [31:0] RF_WriteData;
  logic        ID_Stall;
  logic [31:0] Pending;
`ifdef RFWS_STALL_CNT_EN
  logic [31:0] StallCount;
`endif

  always #5 Clock = ~Clock;

  regfile_write_scheduler #(.DEPTH(DEPTH)) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .WB_RegWrite     (WB_RegWrite),
    .WB_WriteAddress (WB_WriteAddress),
    .WB_WriteData    (WB_WriteData),
    .MC_Valid        (MC_Valid),
    .MC_Ready        (MC_Ready),
    .MC_WriteAddress (MC_WriteAddress),
    .MC_WriteData    (MC_WriteData),
    .MC_Issue        (MC_Issue),
    .MC_IssueAddress (MC_IssueAddress),
    .ID_ReadAddr1    (ID_ReadAddr1),
    .ID_ReadAddr2    (ID_ReadAddr2),
    .ID_DestAddr     (ID_DestAddr),
    .ID_DestValid    (ID_DestValid),
    .RF_RegWrite     (RF_RegWrite),
    .RF_WriteAddress (RF_WriteAddress),
    .RF_WriteData    (RF_WriteData),
    .ID_Stall        (ID_Stall),
    .Pending         (Pending)
`ifdef RFWS_STALL_CNT_EN
    ,
    .StallCount      (StallCount)
`endif
  );

  // Reference model: a queue of waiting results and a set of reserved registers.
  rf_wr_entry_t mq[$];
  logic [31:0]  mPend;
  logic [31:0]  mStallCnt;
  int           nChecks = 0;
  int           nFail   = 0;

  logic         sPop, sByp, sReady, sAccepted;
  logic [4:0]   sHeadAddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    WB_RegWrite = 0; WB_WriteAddress = 0; WB_WriteData = 0;
    MC_Valid = 0; MC_WriteAddress = 0; MC_WriteData = 0;
    MC_Issue = 0; MC_IssueAddress = 0;
    ID_ReadAddr1 = 0; ID_ReadAddr2 = 0; ID_DestAddr = 0; ID_DestValid = 0;
  endtask

  task automatic modelReset();
    mq.delete();
    mPend = '0;
    mStallCnt = '0;
  endtask

  // Called shortly before the rising edge: compare every output with the model.
  task automatic settle();
    logic        expWrite;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        expStall;
    #3;
    sReady = (mq.size() < DEPTH);
    sPop = 0; sByp = 0; expWrite = 0; ea = 0; ed = 0; sHeadAddr = 0;
    if (WB_RegWrite) begin
      expWrite = 1; ea = WB_WriteAddress; ed = WB_WriteData;
    end else if (mq.size() > 0) begin
      expWrite = 1; ea = mq[0].addr; ed = mq[0].data; sPop = 1; sHeadAddr = mq[0].addr;
    end else if (MC_Valid) begin
      expWrite = 1; ea = MC_WriteAddress; ed = MC_WriteData; sByp = 1;
    end
    expWrite  = expWrite && (ea != 0);
    sAccepted = MC_Valid && sReady;
    expStall  = mPend[ID_ReadAddr1] | mPend[ID_ReadAddr2] | (ID_DestValid & mPend[ID_DestAddr]);
    chk("rf_we", RF_RegWrite, expWrite);
    if (expWrite) begin
      chk("rf_addr", RF_WriteAddress, ea);
      chk("rf_data", RF_WriteData, ed);
    end
    chk("mc_ready", MC_Ready, sReady);
    chk("pending", Pending, mPend);
    chk("id_stall", ID_Stall, expStall);
`ifdef RFWS_STALL_CNT_EN
    chk("stall_cnt", StallCount, mStallCnt);
`endif
  endtask

  task automatic tick();
    logic expStall;
    expStall = mPend[ID_ReadAddr1] | mPend[ID_ReadAddr2] | (ID_DestValid & mPend[ID_DestAddr]);
    @(posedge Clock);
    if (sPop) begin
      void'(mq.pop_front());
      mPend[sHeadAddr] = 1'b0;
    end else if (sByp) begin
      mPend[MC_WriteAddress] = 1'b0;
    end
    if (MC_Valid && sReady && !sByp) mq.push_back('{addr: MC_WriteAddress, data: MC_WriteData});
    if (MC_Issue && MC_IssueAddress != 0) mPend[MC_IssueAddress] = 1'b1;
    if (expStall && mStallCnt != 32'hFFFF_FFFF) mStallCnt = mStallCnt + 1;
    #1;
  endtask

  logic [4:0]  t3Addr [3];
  logic [31:0] t3Data [3];
  int          t3Idx;

  initial begin
    idleInputs();
    modelReset();
    Reset = 1;
    #12;
    chk("rst_we", RF_RegWrite, 0);
    chk("rst_pending", Pending, 0);
    chk("rst_stall", ID_Stall, 0);
    @(posedge Clock); #1;
    Reset = 0;
    settle();
    chk("rst_ready", MC_Ready, 1);
    tick();

    // Reservation of r8, stall on read, bypass commit, release next cycle.
    MC_Issue = 1; MC_IssueAddress = 8;
    settle(); tick();
    MC_Issue = 0; ID_ReadAddr1 = 8;
    settle();
    chk("t1_stall", ID_Stall, 1);
    chk("t1_pend8", Pending[8], 1);
    tick();
    MC_Valid = 1; MC_WriteAddress = 8; MC_WriteData = 32'hDEAD_BEEF;
    settle();
    chk("t1_byp_we", RF_RegWrite, 1);
    chk("t1_byp_addr", RF_WriteAddress, 8);
    chk("t1_byp_data", RF_WriteData, 32'hDEAD_BEEF);
    chk("t1_commit_stall", ID_Stall, 1);
    tick();
    MC_Valid = 0;
    settle();
    chk("t1_pend8_clr", Pending[8], 0);
    chk("t1_release", ID_Stall, 0);
    tick();
    ID_ReadAddr1 = 0;

    // WB holds the port for three cycles; r9 waits in the FIFO.
    WB_RegWrite = 1; WB_WriteAddress = 3; WB_WriteData = 32'h11;
    MC_Valid = 1; MC_WriteAddress = 9; MC_WriteData = 32'h22;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t2_wb_addr", RF_WriteAddress, 3);
      tick();
      MC_Valid = 0;
    end
    WB_RegWrite = 0;
    settle();
    chk("t2_mc_addr", RF_WriteAddress, 9);
    chk("t2_mc_data", RF_WriteData, 32'h22);
    tick();

    // Backpressure: WB busy four cycles, three results offered.
    t3Addr[0] = 10; t3Addr[1] = 11; t3Addr[2] = 12;
    t3Data[0] = 32'hA0; t3Data[1] = 32'hB1; t3Data[2] = 32'hC2;
    t3Idx = 0;
    for (int i = 0; i < 8; i++) begin
      WB_RegWrite = (i < 4); WB_WriteAddress = 5'(i + 1); WB_WriteData = 32'(i);
      MC_Valid = (t3Idx < 3);
      MC_WriteAddress = t3Addr[t3Idx < 3 ? t3Idx : 0];
      MC_WriteData = t3Data[t3Idx < 3 ? t3Idx : 0];
      settle();
      if (i == 2) chk("t3_full_ready", MC_Ready, 0);
      if (i >= 4 && i <= 6) chk("t3_order", RF_WriteAddress, 32'(6 + i));
      tick();
      if (sAccepted) t3Idx++;
    end
    chk("t3_all_taken", t3Idx, 3);
    idleInputs();

    // New reservation of r5 in the cycle its previous result commits.
    MC_Issue = 1; MC_IssueAddress = 5;
    settle(); tick();
    MC_Valid = 1; MC_WriteAddress = 5; MC_WriteData = 32'h55;
    settle(); tick();
    idleInputs();
    settle();
    chk("t4_set_wins", Pending[5], 1);
    tick();

    // Results to r0: queued, drained without a write, never reserved or stalled.
    WB_RegWrite = 1; WB_WriteAddress = 2; WB_WriteData = 32'h2;
    MC_Valid = 1; MC_WriteAddress = 0; MC_WriteData = 32'h77;
    MC_Issue = 1; MC_IssueAddress = 0;
    settle(); tick();
    idleInputs();
    ID_DestValid = 1;
    settle();
    chk("t5_r0_we", RF_RegWrite, 0);
    chk("t5_r0_stall", ID_Stall, 0);
    chk("t5_r0_pend", Pending[0], 0);
    tick();
    settle();
    chk("t5_drained", MC_Ready, 1);
    tick();

    // Reset mid-operation with two queued results and reservations.
    idleInputs();
    WB_RegWrite = 1; WB_WriteAddress = 1;
    MC_Issue = 1; MC_IssueAddress = 20;
    for (int i = 0; i < 2; i++) begin
      MC_Valid = 1; MC_WriteAddress = 5'(20 + i); MC_WriteData = 32'(i);
      settle(); tick();
      MC_Issue = 0;
    end
    idleInputs();
    ID_ReadAddr1 = 20;
    #2;
    Reset = 1;
    #1;
    modelReset();
    chk("t6_pend_clr", Pending, 0);
    chk("t6_we", RF_RegWrite, 0);
    chk("t6_stall", ID_Stall, 0);
    chk("t6_ready", MC_Ready, 1);
`ifdef RFWS_STALL_CNT_EN
    chk("t6_stallcnt", StallCount, 0);
`endif
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 0;
    settle();
    chk("t6_no_write", RF_RegWrite, 0);
    tick();

    // Randomized traffic; producer holds each result until the model says it was taken.
    idleInputs();
    for (int i = 0; i < 600; i++) begin
      WB_RegWrite = ($urandom_range(0, 9) < 6);
      WB_WriteAddress = 5'($urandom_range(0, 7));
      WB_WriteData = $urandom;
      if (!MC_Valid || sAccepted) begin
        MC_Valid = ($urandom_range(0, 2) != 0);
        MC_WriteAddress = 5'($urandom_range(0, 7));
        MC_WriteData = $urandom;
      end
      MC_Issue = ($urandom_range(0, 9) < 3);
      MC_IssueAddress = 5'($urandom_range(0, 7));
      ID_ReadAddr1 = 5'($urandom_range(0, 7));
      ID_ReadAddr2 = 5'($urandom_range(0, 7));
      ID_DestAddr = 5'($urandom_range(0, 7));
      ID_DestValid = 1'($urandom_range(0, 1));
      sAccepted = 0;
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
Arbitrates the single register-file write port between the in-order WB stage and an out-of-band multi-cycle unit (mult/div).
- Buffers multi-cycle results in a small FIFO until the port is free.
- Keeps a 32-entry pending scoreboard of destinations reserved by issued multi-cycle ops.
- Drives ID_Stall to the hazard logic when an ID-stage operand or destination is still pending.

Parameters:
DEPTH, 2, multi-cycle result FIFO entries; power of two, >=2
STALL_CNT_W, 32, width of the optional stall counter

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
WB_RegWrite  in  1  WB stage write request (never stalled)
WB_WriteAddress  in  5  WB destination
WB_WriteData  in  32  WB data
MC_Valid  in  1  multi-cycle result valid
MC_Ready  out  1  FIFO can accept (registered, = !full)
MC_WriteAddress  in  5  multi-cycle destination
MC_WriteData  in  32  multi-cycle result
MC_Issue  in  1  multi-cycle op leaving ID this cycle; reserves destination
MC_IssueAddress  in  5  destination being reserved
ID_ReadAddr1  in  5  ID rs
ID_ReadAddr2  in  5  ID rt
ID_DestAddr  in  5  ID destination
ID_DestValid  in  1  ID instruction writes a register
RF_RegWrite  out  1  register-file write enable
RF_WriteAddress  out  5  register-file write address
RF_WriteData  out  32  register-file write data
ID_Stall  out  1  hold PC/IFID, bubble ID/EX
Pending  out  32  scoreboard, bit n = register n reserved
StallCount  out  STALL_CNT_W  only with RFWS_STALL_CNT_EN

Behaviour:
- Reset (async, high):
  - FIFO empty; Pending=0; MC_Ready=1 after reset release.
  - RF_RegWrite forced 0 while Reset is high.
  - ID_Stall=0; StallCount=0.
- Port selection (combinational, same cycle), priority order:
  - WB_RegWrite=1: WB owns the port. RF_* = WB inputs.
  - else FIFO non-empty: pop head. RF_* = head entry.
  - else MC_Valid=1 and FIFO empty: bypass. RF_* = MC inputs. The result is not enqueued.
  - else RF_RegWrite=0.
- Handshake:
  - MC_Valid&&MC_Ready accepts one result per cycle.
  - Enqueue happens unless that result was bypassed this cycle.
  - Simultaneous push and pop when full: not possible, because MC_Ready=0 when full. The producer holds MC_Valid/data until accepted.
  - Push and pop in the same cycle when partially full: occupancy unchanged, order preserved.
- Address 0:
  - Any write to r0 has RF_RegWrite=0, but the FIFO entry is still consumed and the scoreboard bit is handled.
  - Pending[0] is never set.
  - Address 0 never causes a stall.
- Scoreboard:
  - Set Pending[MC_IssueAddress] on MC_Issue (address != 0).
  - Clear Pending[a] on the cycle a multi-cycle write to a is committed (FIFO pop or bypass).
  - If set and clear hit the same register in the same cycle, set wins.
  - WB commits never clear Pending.
- Stall (combinational from registered Pending):
  - ID_Stall = Pending[ID_ReadAddr1] | Pending[ID_ReadAddr2] | (ID_DestValid & Pending[ID_DestAddr]).
  - A register is stalled on during its commit cycle and released the next cycle, because RF write-then-read is not guaranteed same-cycle.
- Starvation: continuous WB writes can fill the FIFO. MC_Ready=0 backpressures the unit, which owns its own stall. No data is lost.
- Reset mid-operation: FIFO contents and Pending are discarded immediately. No write is issued for them.

Optional Feature:
RFWS_STALL_CNT_EN
- Defined: StallCount increments each cycle ID_Stall=1 and saturates at all-ones. It clears on Reset.
- Undefined: the StallCount port and counter are absent, with no other behavioural change.

Decomposition:
- Shared package:
  - NUM_REGS=32, REG_ADDR_W=5, REG_ZERO=5'd0.
  - Typedef rf_wr_entry_t {addr[4:0], data[31:0]}.
- Sub-module rfws_fifo: DEPTH-entry synchronous FIFO with push/pop/full/empty and async reset.
- Arbitration, scoreboard and stall logic stay in the top module.

Test Plan:
- Issue MC to r8; next cycle ID_ReadAddr1=8 -> ID_Stall=1 and Pending[8]=1. MC_Valid r8=0xDEADBEEF with WB idle -> bypass, RF_RegWrite=1 addr 8, Pending[8]=0 next cycle, stall drops.
- WB_RegWrite r3=0x11 held 3 cycles while MC_Valid r9=0x22 -> RF writes r3 each cycle. r9 is enqueued, then written the first cycle WB is idle.
- WB busy 4 cycles with DEPTH=2 and 3 MC results offered -> MC_Ready=0 after 2 accepts. Results drain in order and none are lost or duplicated.
- MC_Issue r5 in the same cycle r5's previous result commits -> Pending[5] remains 1.
- MC result to r0 -> RF_RegWrite=0, FIFO drains, ID reads of r0 never stall.
- Assert Reset with 2 FIFO entries and Pending!=0 -> all cleared asynchronously, no RF write after release. With RFWS_STALL_CNT_EN defined, StallCount=0.
